// File: rtl/alu_pkg.sv
// Shared ALU opcode set and arbiter state encoding, imported by the ALU and the
// alu_arbiter slice.
package alu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_NAND = 3'd2,
    OP_XOR  = 3'd3,
    OP_INC  = 3'd4,
    OP_SRA  = 3'd5,
    OP_SRL  = 3'd6,
    OP_SLL  = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  // Flags with a sign meaning are only produced by the add/subtract pair.
  function automatic logic op_is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Two-requester operation bus plus registered response channel of alu_arbiter.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [2:0]        req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req0_lock;

  logic              req1_valid;
  logic              req1_ready;
  logic [2:0]        req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              req1_lock;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_z;
  logic              rsp_v;
  logic              rsp_n;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_lock,
    input  req1_valid, req1_op, req1_a, req1_b, req1_lock,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_z, rsp_v, rsp_n
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_lock,
    output req1_valid, req1_op, req1_a, req1_b, req1_lock,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_z, rsp_v, rsp_n
  );

endinterface

// File: rtl/alu_arbiter_alu_16.sv
// ALU_16: combinational 16-bit ALU producing result plus z/v/n flags.
module alu_16
  import alu_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              v,
  output logic              n
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              v_add;
  logic              v_sub;
  logic [3:0]        sh;

  always_comb begin
    sum   = a + b;
    diff  = a - b;
    sh    = b[3:0];
    v_add = (a[15] == b[15]) && (sum[15] != a[15]);
    v_sub = (a[15] != b[15]) && (diff[15] != a[15]);
    result = '0;
    unique case (alu_op_t'(op))
      OP_ADD:  result = sum;
      OP_SUB:  result = diff;
      OP_NAND: result = ~(a & b);
      OP_XOR:  result = a ^ b;
      OP_INC:  result = a + 16'd1;
      OP_SRA:  result = $unsigned($signed(a) >>> sh);
      OP_SRL:  result = a >> sh;
      OP_SLL:  result = a << sh;
      default: result = '0;
    endcase
    z = (result == '0);
    n = op_is_arith(op) ? result[15] : 1'b0;
    // Overflow reports the subtract check for every op other than ADD.
    v = (alu_op_t'(op) == OP_ADD) ? v_add : v_sub;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port lockable arbiter in front of a single ALU_16 with a one-deep response
// register. Define ALU_ARBITER_RR_EN for round-robin idle arbitration.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 4
) (
  input logic         clk,
  input logic         rst,
  alu_arbiter_if.slave bus
);

  arb_state_t        state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              ptr, ptr_nx;

  logic              slot_free;
  logic              win1;
  logic              rdy0, rdy1;
  logic              xfer;
  logic              gid;
  logic              glock;
  logic [CNT_W-1:0]  cnt_inc;

  logic [2:0]        g_op;
  logic [DATA_W-1:0] g_a, g_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_z, alu_v, alu_n;

  logic              rsp_valid_q;
  logic              rsp_id_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic              rsp_z_q, rsp_v_q, rsp_n_q;

  assign slot_free = !rsp_valid_q || bus.rsp_ready;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ptr_nx   = ptr;
    win1     = 1'b0;
    rdy0     = 1'b0;
    rdy1     = 1'b0;
    cnt_inc  = cnt + 4'd1;

    unique case (state)
      IDLE: begin
        if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_ARBITER_RR_EN
          win1 = (ptr == 1'b0);
`else
          win1 = 1'b0;
`endif
        end else begin
          win1 = bus.req1_valid;
        end
        rdy0 = slot_free && bus.req0_valid && !win1;
        rdy1 = slot_free && bus.req1_valid && win1;
      end
      LOCK0:   rdy0 = slot_free && bus.req0_valid;
      LOCK1:   rdy1 = slot_free && bus.req1_valid;
      default: state_nx = IDLE;
    endcase

    if (rst) begin
      rdy0 = 1'b0;
      rdy1 = 1'b0;
    end

    xfer  = rdy0 || rdy1;
    gid   = rdy1;
    glock = gid ? bus.req1_lock : bus.req0_lock;

    if (xfer) begin
      ptr_nx = gid;
      if (state == IDLE) begin
        if (glock) begin
          state_nx = gid ? LOCK1 : LOCK0;
          cnt_nx   = 4'd1;
        end
      end else if (!glock || cnt_inc == CNT_W'(LOCK_MAX)) begin
        // Hitting the lock budget releases ownership even if lock is still asked.
        state_nx = IDLE;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ptr   <= ptr_nx;
    end
  end

  assign g_op = gid ? bus.req1_op : bus.req0_op;
  assign g_a  = gid ? bus.req1_a  : bus.req0_a;
  assign g_b  = gid ? bus.req1_b  : bus.req0_b;

  alu_16 u_alu (
    .op     (g_op),
    .a      (g_a),
    .b      (g_b),
    .result (alu_result),
    .z      (alu_z),
    .v      (alu_v),
    .n      (alu_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_z_q      <= 1'b0;
      rsp_v_q      <= 1'b0;
      rsp_n_q      <= 1'b0;
    end else if (xfer) begin
      rsp_valid_q  <= 1'b1;
      rsp_id_q     <= gid;
      rsp_result_q <= alu_result;
      rsp_z_q      <= alu_z;
      rsp_v_q      <= alu_v;
      rsp_n_q      <= alu_n;
    end else if (bus.rsp_ready) begin
      rsp_valid_q  <= 1'b0;
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_z      = rsp_z_q;
  assign bus.rsp_v      = rsp_v_q;
  assign bus.rsp_n      = rsp_n_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_alu_arbiter;

  localparam int LOCK_MAX = 4;
`ifdef ALU_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if bus ();

  alu_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          owner;
  int          run;
  int          ptr;
  logic        exp_valid;
  logic        exp_id;
  logic [15:0] exp_res;
  logic        exp_z, exp_v, exp_n;
  int          last_grant;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ovf(input int x);
    return (x > 32767) || (x < -32768);
  endfunction

  function automatic void alu_ref(input int op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic z, output logic v,
                                  output logic n);
    int sa, sb, sh, full;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(b[3:0]);
    full = sa - sb;
    v = ovf(full);
    case (op)
      0: begin full = sa + sb; r = full[15:0]; v = ovf(full); end
      1: r = full[15:0];
      2: r = ~(a & b);
      3: r = a ^ b;
      4: r = a + 16'd1;
      5: begin full = sa >>> sh; r = full[15:0]; end
      6: r = a >> sh;
      default: r = a << sh;
    endcase
    n = (op <= 1) ? r[15] : 1'b0;
    z = (r == 16'd0);
  endfunction

  function automatic void model_reset();
    owner = -1;
    run = 0;
    ptr = 1;
    exp_valid = 1'b0;
  endfunction

  task automatic drive(input logic v0, input int op0, input logic [15:0] a0, input logic [15:0] b0,
                       input logic l0, input logic v1, input int op1, input logic [15:0] a1,
                       input logic [15:0] b1, input logic l1, input logic rr);
    bus.req0_valid = v0; bus.req0_op = 3'(op0); bus.req0_a = a0; bus.req0_b = b0; bus.req0_lock = l0;
    bus.req1_valid = v1; bus.req1_op = 3'(op1); bus.req1_a = a1; bus.req1_b = b1; bus.req1_lock = l1;
    bus.rsp_ready = rr;
  endtask

  task automatic step();
    logic fr, e0, e1, rr, lk;
    logic v0, v1, l0, l1;
    logic [2:0] op0, op1;
    logic [15:0] a0, b0, a1, b1;
    int g;
    @(negedge clk);
    v0 = bus.req0_valid; op0 = bus.req0_op; a0 = bus.req0_a; b0 = bus.req0_b; l0 = bus.req0_lock;
    v1 = bus.req1_valid; op1 = bus.req1_op; a1 = bus.req1_a; b1 = bus.req1_b; l1 = bus.req1_lock;
    rr = bus.rsp_ready;
    fr = !exp_valid || rr;
    e0 = 1'b0;
    e1 = 1'b0;
    if (owner == 0) e0 = fr && v0;
    else if (owner == 1) e1 = fr && v1;
    else if (v0 && v1) begin
      if (RR && ptr == 0) e1 = fr; else e0 = fr;
    end else begin
      e0 = fr && v0;
      e1 = fr && v1;
    end
    chk("ready0", 16'(bus.req0_ready), 16'(e0));
    chk("ready1", 16'(bus.req1_ready), 16'(e1));
    last_grant = bus.req1_ready ? 1 : (bus.req0_ready ? 0 : -1);
    g = e1 ? 1 : (e0 ? 0 : -1);
    @(posedge clk);
    #1;
    if (g >= 0) begin
      if (g == 1) alu_ref(int'(op1), a1, b1, exp_res, exp_z, exp_v, exp_n);
      else        alu_ref(int'(op0), a0, b0, exp_res, exp_z, exp_v, exp_n);
      exp_valid = 1'b1;
      exp_id = (g == 1);
      ptr = g;
      lk = (g == 1) ? l1 : l0;
      if (owner < 0) begin
        if (lk) begin owner = g; run = 1; end
      end else begin
        run++;
        if (run == LOCK_MAX || !lk) begin owner = -1; run = 0; end
      end
    end else if (rr) begin
      exp_valid = 1'b0;
    end
    chk("rsp_valid", 16'(bus.rsp_valid), 16'(exp_valid));
    if (exp_valid) begin
      chk("rsp_id", 16'(bus.rsp_id), 16'(exp_id));
      chk("rsp_result", bus.rsp_result, exp_res);
      chk("rsp_z", 16'(bus.rsp_z), 16'(exp_z));
      chk("rsp_v", 16'(bus.rsp_v), 16'(exp_v));
      chk("rsp_n", 16'(bus.rsp_n), 16'(exp_n));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 16'(bus.rsp_valid), 16'd0);
    chk({tag, "_result"}, bus.rsp_result, 16'd0);
    chk({tag, "_id"}, 16'(bus.rsp_id), 16'd0);
    chk({tag, "_flags"}, 16'({bus.rsp_z, bus.rsp_v, bus.rsp_n}), 16'd0);
    chk({tag, "_rdy0"}, 16'(bus.req0_ready), 16'd0);
    chk({tag, "_rdy1"}, 16'(bus.req1_ready), 16'd0);
  endtask

  task automatic do_reset();
    drive(1, 0, 16'h1, 16'h1, 0, 1, 0, 16'h2, 16'h2, 0, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    model_reset();
    rst = 1'b0;
  endtask

  int grants[4];
  int n1;
  bit got0;

  initial begin
    model_reset();
    last_grant = -1;
    do_reset();

    // Port0 ADD overflow into the sign bit
    drive(1, 0, 16'h7FFF, 16'h0001, 0, 0, 0, 16'h0, 16'h0, 0, 1);
    step();
    chk("add_id", 16'(bus.rsp_id), 16'd0);
    chk("add_res", bus.rsp_result, 16'h8000);
    chk("add_nvz", 16'({bus.rsp_n, bus.rsp_v, bus.rsp_z}), 16'b110);

    // SUB to zero, then SLL by 4
    drive(1, 1, 16'h0005, 16'h0005, 0, 0, 0, 16'h0, 16'h0, 0, 1);
    step();
    chk("sub_res", bus.rsp_result, 16'h0000);
    chk("sub_znv", 16'({bus.rsp_z, bus.rsp_n, bus.rsp_v}), 16'b100);
    drive(1, 7, 16'h0001, 16'h0004, 0, 0, 0, 16'h0, 16'h0, 0, 1);
    step();
    chk("sll_res", bus.rsp_result, 16'h0010);
    chk("sll_n", 16'(bus.rsp_n), 16'd0);

    // Both valid, no lock, starting from reset
    do_reset();
    drive(1, 3, 16'hAAAA, 16'h5555, 0, 1, 2, 16'hF0F0, 16'h0FF0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      grants[i] = last_grant;
    end
    for (int i = 0; i < 4; i++)
      chk("alt_grant", 16'(grants[i]), RR ? 16'(i % 2) : 16'd0);

    // Back-pressure: pending response with consumer stalled
    drive(1, 4, 16'hFFFF, 16'h0, 0, 1, 5, 16'h8000, 16'h0003, 0, 0);
    for (int i = 0; i < 3; i++) step();
    drive(0, 4, 16'h0, 16'h0, 0, 1, 6, 16'h8000, 16'h0003, 0, 1);
    step();
    chk("drain_load_id", 16'(bus.rsp_id), 16'd1);
    chk("drain_load_res", bus.rsp_result, 16'h1000);

    // Port1 holds a lock while port0 keeps requesting
    drive(0, 0, 16'h1, 16'h2, 0, 1, 0, 16'h10, 16'h20, 1, 1);
    n1 = 0;
    got0 = 1'b0;
    step();
    if (last_grant == 1) n1++;
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_grant == 1) n1++;
      else if (last_grant == 0) begin got0 = 1'b1; break; end
    end
    chk("lock_count", 16'(n1), 16'(LOCK_MAX));
    chk("lock_release", 16'(got0), 16'd1);

    // Asynchronous reset in the middle of a lock
    drive(0, 0, 16'h1, 16'h2, 0, 1, 3, 16'h33, 16'h11, 1, 1);
    step();
    step();
    chk("prelock_valid", 16'(bus.rsp_valid), 16'd1);
    #3 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1, 0, 16'h4, 16'h5, 0, 1, 0, 16'h6, 16'h7, 0, 1);
    step();
    chk("post_rst_grant", 16'(last_grant), 16'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(9, 0) < 6, $urandom_range(7, 0), 16'($urandom), 16'($urandom),
            $urandom_range(9, 0) < 4,
            $urandom_range(9, 0) < 6, $urandom_range(7, 0), 16'($urandom), 16'($urandom),
            $urandom_range(9, 0) < 4,
            $urandom_range(9, 0) < 7);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
